gmii_frame_tx: RTL and testbench
================================

# gmii_frame_tx

Frame replay transmitter sitting directly downstream of the frame buffer memory. Pops one frame-length descriptor and the matching payload bytes from the buffer's show-ahead FIFOs. Regenerates a GMII transmit stream: 7-byte preamble, SFD, payload, then a programmable inter-frame gap. Closes the pcap → GMII rx → frame_receiver → buffer → GMII tx loop in the copy-packet design.

## Interface
Parameters:
- pIFG_BYTES, 12: idle cycles between frames (tx_en low); legal range 1–15.
- pPREAMBLE_LEN, 7: number of 0x55 bytes before SFD; legal range 1–7.
- pMAX_LEN, 1518: largest frame transmitted; longer descriptors are dropped.

Ports:
- iclk, in, 1: clock; all state on rising edge.
- i_rst_n, in, 1: reset, asynchronous and active-low.
- i_desc_empty, in, 1: descriptor FIFO empty.
- i_desc_len, in, 11: frame length in bytes at FIFO head (show-ahead).
- o_desc_rd, out, 1: descriptor pop, one-cycle pulse.
- i_data_empty, in, 1: payload FIFO empty.
- i_data, in, 8: payload byte at FIFO head (show-ahead).
- o_data_rd, out, 1: payload pop; one byte per asserted cycle.
- o_tx_en, out, 1: GMII TX_EN, registered.
- o_txd, out, 8: GMII TXD, registered.
- o_tx_er, out, 1: GMII TX_ER, registered.
- o_busy, out, 1: high in any state other than IDLE.
- o_underrun, out, 1: one-cycle pulse per underrun byte.
- o_frame_cnt, out, 16: frames fully transmitted, wraps at 0xFFFF→0.

## Operation
Reset (i_rst_n low) forces the following, asynchronously:
- State goes to IDLE.
- o_tx_en, o_tx_er, o_desc_rd, o_data_rd, o_busy, o_underrun all = 0.
- o_txd = 0x00.
- o_frame_cnt = 0.
- Internal counters = 0.

States:
- IDLE: if !i_desc_empty, pulse o_desc_rd and latch i_desc_len into an 11-bit down-counter.
  - len == 0 → stay in IDLE; no output.
  - len > pMAX_LEN → DROP.
  - otherwise → PREAMBLE.
- PREAMBLE: emit 0x55 for pPREAMBLE_LEN cycles, then → SFD.
- SFD: emit 0xD5 for one cycle, then → PAYLOAD.
- PAYLOAD:
  - If !i_data_empty: o_data_rd=1 and o_txd ← i_data; decrement the counter.
  - Last byte (counter == 1 when popped) → IFG, and o_frame_cnt increments.
  - If i_data_empty: o_tx_en=1, o_tx_er=1, o_txd=0x00, o_underrun pulses. No pop, counter unchanged; stay in PAYLOAD until data arrives.
- IFG: o_tx_en=0 for pIFG_BYTES cycles, then → IDLE.
- DROP: pop payload bytes whenever !i_data_empty until the latched length is consumed, then → IDLE.
  - o_tx_en stays 0 throughout.
  - o_frame_cnt does not increment.
- o_desc_rd is asserted only in IDLE, and never while i_desc_empty=1.
- o_data_rd is asserted only in PAYLOAD/DROP, and never while i_data_empty=1.
- Reset mid-frame: output drops immediately with no tail; FIFO contents are not touched. Flushing them is the buffer's responsibility.

## Timing
- o_desc_rd/o_data_rd are combinational from state and the FIFO empty flags. All GMII outputs are registered.
- Descriptor pop at cycle N → first 0x55 on o_txd at N+1. SFD at N+1+pPREAMBLE_LEN. First payload byte at N+2+pPREAMBLE_LEN, assuming data is available.
- Byte popped at cycle M appears on o_txd at M+1.
- Last payload byte at cycle L → o_tx_en low from L+1 through L+pIFG_BYTES. The earliest next descriptor pop is at L+pIFG_BYTES+1.
- Back-to-back frames: minimum gap on the wire is pIFG_BYTES+1 cycles of o_tx_en=0, because the IDLE decision cycle adds one.
- An oversize descriptor costs 1 cycle plus len data pops, with no wire activity.

## Structure
- Shared package:
  - state enum: IDLE, PREAMBLE, SFD, PAYLOAD, IFG, DROP.
  - constants: PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, LEN_W=11.
- Single module, no sub-module: one FSM, an 11-bit byte counter, and a 4-bit phase counter shared by PREAMBLE and IFG.

## Test plan
- One 64-byte descriptor with data bytes 0x00..0x3F preloaded:
  - o_txd shows 7×0x55, 0xD5, then 0x00..0x3F, with o_tx_en high for exactly 72 cycles.
  - o_tx_er never asserts; o_frame_cnt=1.
- Two 60-byte frames queued back-to-back: o_tx_en is low for exactly 13 cycles between frames; o_frame_cnt=2.
- Descriptor len=0, then len=60: the first is consumed with no o_tx_en activity; the second transmits normally.
- Descriptor len=1600 with 1600 data bytes, followed by a 64-byte frame:
  - All 1600 bytes are popped with o_tx_en=0.
  - The 64-byte frame transmits correctly; o_frame_cnt=1.
- Data FIFO held empty for 3 cycles after the 10th payload byte:
  - 3 cycles of o_tx_en=1, o_tx_er=1, o_txd=0x00, with 3 o_underrun pulses.
  - The remaining bytes follow in order, and the total payload count is correct.
- i_rst_n asserted during the 20th payload byte:
  - Same cycle: o_tx_en=0, o_txd=0x00, o_frame_cnt=0.
  - After release, a new 64-byte frame transmits correctly.

Source files
------------

// File: rtl/gmii_frame_tx_pkg.sv
// Shared state encoding and wire constants for the GMII frame replay transmitter.
package gmii_frame_tx_pkg;

  localparam int LEN_W = 11;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    IFG,
    DROP
  } tx_state_t;

  // A descriptor is put on the wire only when it is non-empty and fits the size limit.
  function automatic logic len_sendable(input logic [LEN_W-1:0] len,
                                        input logic [LEN_W-1:0] max_len);
    return (len != '0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/gmii_frame_tx.sv
// Replays buffered frames onto GMII TX: preamble, SFD, payload, inter-frame gap.
// The FSM runs one cycle ahead of the wire because every GMII output is registered.
module gmii_frame_tx
  import gmii_frame_tx_pkg::*;
#(
  parameter int pIFG_BYTES    = 12,
  parameter int pPREAMBLE_LEN = 7,
  parameter int pMAX_LEN      = 1518
) (
  input  logic             iclk,
  input  logic             i_rst_n,
  input  logic             i_desc_empty,
  input  logic [LEN_W-1:0] i_desc_len,
  output logic             o_desc_rd,
  input  logic             i_data_empty,
  input  logic [7:0]       i_data,
  output logic             o_data_rd,
  output logic             o_tx_en,
  output logic [7:0]       o_txd,
  output logic             o_tx_er,
  output logic             o_busy,
  output logic             o_underrun,
  output logic [15:0]      o_frame_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(pMAX_LEN);
  localparam logic [3:0]       PRE_LAST = 4'(pPREAMBLE_LEN - 2);
  // IFG lasts one extra cycle: the IDLE decision slot makes the wire gap pIFG_BYTES+1.
  localparam logic [3:0]       IFG_LAST = 4'(pIFG_BYTES);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [LEN_W-1:0] byte_cnt;
  logic [3:0]       phase_cnt;

  logic             desc_rd;
  logic             data_rd;
  logic             tx_en_d;
  logic             tx_er_d;
  logic [7:0]       txd_d;
  logic             underrun_d;
  logic             frame_done;
  logic             last_byte;

  assign last_byte = (byte_cnt == LEN_W'(1));

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!i_desc_empty) begin
          if (i_desc_len == '0) begin
            state_next = IDLE;
          end else if (i_desc_len > MAX_LEN) begin
            state_next = DROP;
          end else if (pPREAMBLE_LEN > 1) begin
            state_next = PREAMBLE;
          end else begin
            state_next = SFD;
          end
        end
      end
      PREAMBLE: begin
        if (phase_cnt == PRE_LAST) begin
          state_next = SFD;
        end
      end
      SFD: begin
        state_next = PAYLOAD;
      end
      PAYLOAD: begin
        if (!i_data_empty && last_byte) begin
          state_next = IFG;
        end
      end
      IFG: begin
        if (phase_cnt == IFG_LAST) begin
          state_next = IDLE;
        end
      end
      DROP: begin
        if (!i_data_empty && last_byte) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The IDLE pop cycle already loads the first preamble byte so it hits the wire next cycle.
  always_comb begin
    desc_rd    = 1'b0;
    data_rd    = 1'b0;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    txd_d      = 8'h00;
    underrun_d = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (!i_desc_empty) begin
          desc_rd = 1'b1;
          if (len_sendable(i_desc_len, MAX_LEN)) begin
            tx_en_d = 1'b1;
            txd_d   = PREAMBLE_BYTE;
          end
        end
      end
      PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = PREAMBLE_BYTE;
      end
      SFD: begin
        tx_en_d = 1'b1;
        txd_d   = SFD_BYTE;
      end
      PAYLOAD: begin
        tx_en_d = 1'b1;
        if (!i_data_empty) begin
          data_rd    = 1'b1;
          txd_d      = i_data;
          frame_done = last_byte;
        end else begin
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
        end
      end
      DROP: begin
        data_rd = !i_data_empty;
      end
      default: begin
        tx_en_d = 1'b0;
      end
    endcase
  end

  assign o_desc_rd = desc_rd & i_rst_n;
  assign o_data_rd = data_rd & i_rst_n;
  assign o_busy    = (state != IDLE);

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_cnt  <= '0;
      phase_cnt <= '0;
    end else begin
      if (desc_rd) begin
        byte_cnt <= i_desc_len;
      end else if (data_rd) begin
        byte_cnt <= byte_cnt - LEN_W'(1);
      end
      if (state_next != state) begin
        phase_cnt <= '0;
      end else if (state == PREAMBLE || state == IFG) begin
        phase_cnt <= phase_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_en     <= 1'b0;
      o_tx_er     <= 1'b0;
      o_txd       <= 8'h00;
      o_underrun  <= 1'b0;
      o_frame_cnt <= 16'd0;
    end else begin
      o_tx_en    <= tx_en_d;
      o_tx_er    <= tx_er_d;
      o_txd      <= txd_d;
      o_underrun <= underrun_d;
      if (frame_done) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed bench for gmii_frame_tx: show-ahead FIFO models feed the DUT, the wire is logged
// every cycle and compared against streams built from the vector table.
module tb_gmii_frame_tx;

  logic        iclk = 1'b0;
  logic        i_rst_n;
  logic        i_desc_empty;
  logic [10:0] i_desc_len;
  logic        o_desc_rd;
  logic        i_data_empty;
  logic [7:0]  i_data;
  logic        o_data_rd;
  logic        o_tx_en;
  logic [7:0]  o_txd;
  logic        o_tx_er;
  logic        o_busy;
  logic        o_underrun;
  logic [15:0] o_frame_cnt;

  gmii_frame_tx #(
    .pIFG_BYTES   (12),
    .pPREAMBLE_LEN(7),
    .pMAX_LEN     (1518)
  ) dut (
    .iclk        (iclk),
    .i_rst_n     (i_rst_n),
    .i_desc_empty(i_desc_empty),
    .i_desc_len  (i_desc_len),
    .o_desc_rd   (o_desc_rd),
    .i_data_empty(i_data_empty),
    .i_data      (i_data),
    .o_data_rd   (o_data_rd),
    .o_tx_en     (o_tx_en),
    .o_txd       (o_txd),
    .o_tx_er     (o_tx_er),
    .o_busy      (o_busy),
    .o_underrun  (o_underrun),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int         len;
    logic [7:0] seed;
    int         stall_at;
    int         exp_en;
    int         exp_frames;
    int         exp_underruns;
  } vec_t;

  logic [10:0] desc_q[$];
  logic [7:0]  data_q[$];
  logic        wave_en[$];
  logic [7:0]  wave_d[$];
  logic        wave_er[$];
  logic        wave_ur[$];

  int n_checks = 0;
  int n_pass = 0;
  int exp_frames = 0;
  int desc_pops;
  int data_pops;
  int desc_pop_idx;
  int rd_viol;
  int stall_at;
  int stall_left = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive_fifo();
    i_desc_empty = (desc_q.size() == 0);
    i_desc_len   = i_desc_empty ? 11'd0 : desc_q[0];
    i_data_empty = (data_q.size() == 0) || (stall_left > 0);
    i_data       = (data_q.size() == 0) ? 8'd0 : data_q[0];
  endtask

  task automatic clear_log();
    wave_en.delete();
    wave_d.delete();
    wave_er.delete();
    wave_ur.delete();
    desc_pops    = 0;
    data_pops    = 0;
    desc_pop_idx = -1;
    rd_viol      = 0;
    stall_left   = 0;
  endtask

  // One clock: sample pops and the wire mid-cycle, then retire pops after the edge.
  task automatic tick();
    logic dr;
    logic pr;
    @(negedge iclk);
    if (o_data_rd && i_data_empty) rd_viol++;
    if (o_desc_rd && i_desc_empty) rd_viol++;
    if (o_desc_rd && desc_pop_idx < 0) desc_pop_idx = wave_en.size();
    wave_en.push_back(o_tx_en);
    wave_d.push_back(o_txd);
    wave_er.push_back(o_tx_er);
    wave_ur.push_back(o_underrun);
    dr = o_desc_rd;
    pr = o_data_rd;
    @(posedge iclk);
    #1;
    if (stall_left > 0) stall_left--;
    if (dr) begin
      void'(desc_q.pop_front());
      desc_pops++;
    end
    if (pr) begin
      void'(data_q.pop_front());
      data_pops++;
      if (stall_at != 0 && data_pops == stall_at) stall_left = 3;
    end
    drive_fifo();
  endtask

  task automatic run_until_idle(input int bound, input string name);
    int  guard;
    bit  done;
    guard = 0;
    done  = 1'b0;
    while (!done && guard < bound) begin
      tick();
      guard++;
      done = (desc_q.size() == 0) && (data_q.size() == 0) && !o_busy;
    end
    checkOutput({name, "_done"}, int'(done), 1);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    logic [8:0] exp_s[$];
    logic [8:0] act_s[$];
    int en_cnt;
    int ur_cnt;
    int bad;
    int first_en;
    clear_log();
    stall_at = v.stall_at;
    desc_q.push_back(11'(v.len));
    for (int b = 0; b < v.len; b++) data_q.push_back(v.seed + 8'(b));
    drive_fifo();
    run_until_idle(v.len + 300, tag);

    if (v.len != 0 && v.len <= 1518) begin
      for (int p = 0; p < 7; p++) exp_s.push_back({1'b0, 8'h55});
      exp_s.push_back({1'b0, 8'hD5});
      for (int b = 0; b < v.len; b++) begin
        exp_s.push_back({1'b0, v.seed + 8'(b)});
        if (v.stall_at != 0 && b + 1 == v.stall_at) begin
          repeat (3) exp_s.push_back(9'h100);
        end
      end
    end

    en_cnt = 0;
    ur_cnt = 0;
    first_en = -1;
    for (int k = 0; k < wave_en.size(); k++) begin
      if (wave_en[k]) begin
        en_cnt++;
        act_s.push_back({wave_er[k], wave_d[k]});
        if (first_en < 0) first_en = k;
      end
      if (wave_ur[k]) ur_cnt++;
    end
    bad = 0;
    for (int k = 0; k < exp_s.size(); k++) begin
      if (k >= act_s.size() || act_s[k] !== exp_s[k]) bad++;
    end

    exp_frames += v.exp_frames;
    checkOutput({tag, "_en_cycles"}, en_cnt, v.exp_en);
    checkOutput({tag, "_stream_len"}, act_s.size(), exp_s.size());
    checkOutput({tag, "_stream_bad"}, bad, 0);
    checkOutput({tag, "_underruns"}, ur_cnt, v.exp_underruns);
    checkOutput({tag, "_data_pops"}, data_pops, v.len);
    checkOutput({tag, "_desc_pops"}, desc_pops, 1);
    checkOutput({tag, "_frame_cnt"}, int'(o_frame_cnt), exp_frames);
    checkOutput({tag, "_rd_when_empty"}, rd_viol, 0);
    if (v.exp_en != 0) begin
      checkOutput({tag, "_latency"}, first_en, desc_pop_idx + 1);
    end
  endtask

  vec_t vecs[9];
  vec_t post_vec;

  initial begin
    int start1;
    int end1;
    int start2;
    int en_tot;
    int frames_before;
    int guard;

    vecs[0] = '{64,   8'h00, 0,  72,   1, 0};
    vecs[1] = '{0,    8'h00, 0,  0,    0, 0};
    vecs[2] = '{60,   8'hA0, 0,  68,   1, 0};
    vecs[3] = '{1600, 8'h00, 0,  0,    0, 0};
    vecs[4] = '{64,   8'h40, 0,  72,   1, 0};
    vecs[5] = '{64,   8'h20, 10, 75,   1, 3};
    vecs[6] = '{1,    8'h7E, 0,  9,    1, 0};
    vecs[7] = '{1518, 8'h33, 0,  1526, 1, 0};
    vecs[8] = '{1519, 8'h99, 0,  0,    0, 0};
    post_vec = '{64, 8'hC0, 0, 72, 1, 0};

    stall_at = 0;
    i_rst_n = 1'b0;
    clear_log();
    drive_fifo();
    repeat (3) @(posedge iclk);
    #1;
    checkOutput("reset_tx_en", int'(o_tx_en), 0);
    checkOutput("reset_txd", int'(o_txd), 0);
    checkOutput("reset_tx_er", int'(o_tx_er), 0);
    checkOutput("reset_busy", int'(o_busy), 0);
    checkOutput("reset_frame_cnt", int'(o_frame_cnt), 0);
    checkOutput("reset_desc_rd", int'(o_desc_rd), 0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Two 60-byte frames queued together: measure the idle gap on the wire.
    clear_log();
    stall_at = 0;
    frames_before = exp_frames;
    desc_q.push_back(11'd60);
    desc_q.push_back(11'd60);
    for (int b = 0; b < 120; b++) data_q.push_back(8'h10 + 8'(b));
    drive_fifo();
    run_until_idle(500, "b2b");
    start1 = -1;
    end1 = -1;
    start2 = -1;
    en_tot = 0;
    for (int k = 0; k < wave_en.size(); k++) begin
      if (wave_en[k]) en_tot++;
      if (start1 < 0 && wave_en[k]) start1 = k;
      else if (start1 >= 0 && end1 < 0 && !wave_en[k]) end1 = k;
      else if (end1 >= 0 && start2 < 0 && wave_en[k]) start2 = k;
    end
    exp_frames = frames_before + 2;
    checkOutput("b2b_gap", start2 - end1, 13);
    checkOutput("b2b_en_cycles", en_tot, 136);
    checkOutput("b2b_frame_cnt", int'(o_frame_cnt), exp_frames);
    checkOutput("b2b_data_pops", data_pops, 120);

    // Reset lands while the 20th payload byte is on the wire.
    clear_log();
    stall_at = 0;
    desc_q.push_back(11'd64);
    for (int b = 0; b < 64; b++) data_q.push_back(8'h80 + 8'(b));
    drive_fifo();
    guard = 0;
    while (data_pops < 20 && guard < 300) begin
      tick();
      guard++;
    end
    checkOutput("rst_reach_20", data_pops, 20);
    checkOutput("rst_pre_txd", int'(o_txd), 32'h93);
    checkOutput("rst_pre_en", int'(o_tx_en), 1);
    checkOutput("rst_pre_frame_cnt", int'(o_frame_cnt), exp_frames);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("rst_tx_en", int'(o_tx_en), 0);
    checkOutput("rst_txd", int'(o_txd), 0);
    checkOutput("rst_frame_cnt", int'(o_frame_cnt), 0);
    checkOutput("rst_busy", int'(o_busy), 0);
    checkOutput("rst_tx_er", int'(o_tx_er), 0);
    @(posedge iclk);
    #1;
    desc_q.delete();
    data_q.delete();
    stall_left = 0;
    drive_fifo();
    i_rst_n = 1'b1;
    exp_frames = 0;
    applyStimulus(post_vec, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
